// File: rtl/idu_arbiter.sv
// Shared 16-bit increment/decrement unit arbitrated between PC, SP and HL.
// Each granted operation takes one EXEC cycle and one RESP cycle.
module idu_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Flush,
  input  logic [2:0]  i_Req,
  input  logic [2:0]  i_Dec,
  input  logic [15:0] i_Op0,
  input  logic [15:0] i_Op1,
  input  logic [15:0] i_Op2,
  output logic [2:0]  o_Grant,
  output logic        o_Busy,
  output logic        o_Valid,
  output logic [2:0]  o_Ack,
  output logic [1:0]  o_Id,
  output logic [15:0] o_Result,
  output logic        o_Carry,
  output logic [1:0]  o_State
);

  // Handshake: a requester holds i_Req high until it sees its o_Ack bit
  // (one cycle, alongside o_Valid), then drops it; a level still high in
  // IDLE is taken as a new operation.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  idx_q;
  logic [15:0] op_q;
  logic        dec_q;
  logic [2:0]  grant_q;
  logic [2:0]  ack_q;
  logic        valid_q;
  logic [1:0]  id_q;
  logic [15:0] result_q;
  logic        carry_q;

  logic [2:0]  rot;
  logic [1:0]  off;
  logic [2:0]  rr_sum;
  logic [1:0]  rr_idx;
  logic [1:0]  fp_idx;
  logic [1:0]  win_idx;
  logic [1:0]  ptr_d;
  logic [15:0] win_op;
  logic        win_dec;
  logic [16:0] sum_d;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Rotate requests so bit 0 is the requester the pointer currently favours.
  always_comb begin
    rot = i_Req;
    case (ptr_q)
      2'd1:    rot = {i_Req[0], i_Req[2:1]};
      2'd2:    rot = {i_Req[1:0], i_Req[2]};
      default: rot = i_Req;
    endcase
    off = rot[0] ? 2'd0 : (rot[1] ? 2'd1 : 2'd2);
    rr_sum = {1'b0, ptr_q} + {1'b0, off};
    rr_idx = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
    fp_idx = i_Req[0] ? 2'd0 : (i_Req[1] ? 2'd1 : 2'd2);
    win_idx = (PRIORITY_MODE == 1) ? fp_idx : rr_idx;
    ptr_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
  end

  always_comb begin
    win_op  = i_Op2;
    win_dec = i_Dec[2];
    case (win_idx)
      2'd0: begin
        win_op  = i_Op0;
        win_dec = i_Dec[0];
      end
      2'd1: begin
        win_op  = i_Op1;
        win_dec = i_Dec[1];
      end
      default: begin
        win_op  = i_Op2;
        win_dec = i_Dec[2];
      end
    endcase
  end

  // Adding 0xFFFF decrements; carry is then set for every nonzero operand.
  assign sum_d = {1'b0, op_q} + {1'b0, {15{dec_q}}, 1'b1};

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      idx_q    <= 2'd0;
      op_q     <= 16'h0000;
      dec_q    <= 1'b0;
      grant_q  <= 3'b000;
      ack_q    <= 3'b000;
      valid_q  <= 1'b0;
      id_q     <= 2'd0;
      result_q <= 16'h0000;
      carry_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ack_q   <= 3'b000;
      case (state_q)
        IDLE: begin
          if (!i_Flush && (|i_Req)) begin
            op_q    <= win_op;
            dec_q   <= win_dec;
            idx_q   <= win_idx;
            grant_q <= onehot(win_idx);
            if (PRIORITY_MODE == 0) ptr_q <= ptr_d;
            state_q <= EXEC;
          end else begin
            grant_q <= 3'b000;
          end
        end
        EXEC: begin
          if (i_Flush) begin
            grant_q <= 3'b000;
            state_q <= IDLE;
          end else begin
            result_q <= sum_d[15:0];
            carry_q  <= sum_d[16];
            id_q     <= idx_q;
            valid_q  <= 1'b1;
            ack_q    <= grant_q;
            state_q  <= RESP;
          end
        end
        RESP: begin
          grant_q <= 3'b000;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= 3'b000;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A flush during RESP cancels the completion pulse in that same cycle.
  assign o_Valid  = valid_q & ~i_Flush;
  assign o_Ack    = ack_q & {3{~i_Flush}};
  assign o_Grant  = grant_q;
  assign o_Busy   = (state_q != IDLE);
  assign o_Id     = id_q;
  assign o_Result = result_q;
  assign o_Carry  = carry_q;
  assign o_State  = state_q;

endmodule

// File: doc/idu_arbiter.md
IDU_ARBITER -- requirements
Module: IDU_Arbiter

Interface
REQ-001 The block SHALL have parameter PRIORITY_MODE, default 0, meaning 0 = round-robin arbitration and 1 = fixed priority with lowest index winning.
REQ-002 The block SHALL have port i_Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_Flush, input, 1 bit: synchronous abort of the in-flight operation.
REQ-005 The block SHALL have port i_Req, input, 3 bits: level request per requester; 0 = PC, 1 = SP, 2 = HL.
REQ-006 The block SHALL have port i_Dec, input, 3 bits: per-requester direction; 1 = decrement, 0 = increment.
REQ-007 The block SHALL have ports i_Op0, i_Op1 and i_Op2, input, 16 bits each: per-requester operand.
REQ-008 The block SHALL have port o_Grant, output, 3 bits: one-hot current owner of the shared datapath.
REQ-009 The block SHALL have port o_Busy, output, 1 bit: high when the state is not IDLE.
REQ-010 The block SHALL have port o_Valid, output, 1 bit: result-valid pulse.
REQ-011 The block SHALL have port o_Ack, output, 3 bits: one-hot completion pulse to the winning requester.
REQ-012 The block SHALL have port o_Id, output, 2 bits: index of the requester that owns o_Result.
REQ-013 The block SHALL have port o_Result, output, 16 bits: the registered result.
REQ-014 The block SHALL have port o_Carry, output, 1 bit: the registered carry out (bit 16 of the add).

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, EXEC and RESP, with IDLE as the reset state.
REQ-016 In IDLE with any i_Req bit high and i_Flush low, the block SHALL pick a winner, latch that requester's operand, i_Dec bit and index, set o_Grant, and go to EXEC.
REQ-017 In IDLE with no request, the state SHALL remain IDLE and o_Grant SHALL be 0.
REQ-018 In EXEC, the block SHALL compute {carry, result} = op + {15{dec}, 1} as a 17-bit add, register o_Result, o_Carry and o_Id, and go to RESP.
REQ-019 In RESP, o_Valid SHALL be 1 and o_Ack SHALL equal o_Grant for exactly one cycle; the next state SHALL be IDLE.
REQ-020 Latency SHALL be: request sampled in IDLE at edge N gives o_Valid high during the cycle after edge N+1; throughput is one operation per 3 cycles.
REQ-021 o_Grant SHALL stay constant from EXEC through RESP and SHALL be 0 in IDLE.
REQ-022 With PRIORITY_MODE = 0, after a grant to index n the highest priority SHALL move to (n+1) mod 3; the pointer SHALL advance only on a grant, and its reset value is 0.
REQ-023 With PRIORITY_MODE = 1, the lowest set i_Req index SHALL always win, and the pointer SHALL be ignored.
REQ-024 i_Req, i_Dec and operand changes after the latch SHALL NOT affect the in-flight operation; it completes even if the request drops.
REQ-025 A requester SHALL drop i_Req in the cycle after its o_Ack; a request still high in IDLE is a new operation.
REQ-026 Arithmetic boundaries SHALL be: increment 0xFFFF gives 0x0000 with carry 1; decrement 0x0000 gives 0xFFFF with carry 0; decrement of any nonzero value gives carry 1; increment of any value other than 0xFFFF gives carry 0.
REQ-027 i_Flush high in EXEC or RESP SHALL force IDLE on the next edge, clear o_Grant and suppress or cancel o_Valid and o_Ack; the pointer SHALL keep its advanced value.
REQ-028 i_Flush high in IDLE SHALL block the grant, with flush taking priority over simultaneous requests.
REQ-029 o_Result, o_Carry and o_Id SHALL hold their last values until the next EXEC completes.

Reset
REQ-030 Asserting i_Reset SHALL, immediately and independent of i_Clk, set the state to IDLE, o_Grant = 0, o_Busy = 0, o_Valid = 0, o_Ack = 0, o_Id = 0, o_Result = 0x0000, o_Carry = 0 and the RR pointer to 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation with no o_Valid; the first grant after deassertion SHALL follow REQ-016.

Verification
REQ-032 Single request: i_Req = 001, i_Op0 = 0x1234, i_Dec = 0 -> o_Grant = 001 for 2 cycles, then o_Valid and o_Ack = 001 with o_Result = 0x1235, o_Carry = 0, o_Id = 0.
REQ-033 Wrap cases: SP increment of 0xFFFF -> 0x0000 with carry 1; HL decrement of 0x0000 -> 0xFFFF with carry 0; HL decrement of 0x0001 -> 0x0000 with carry 1.
REQ-034 Round-robin: i_Req = 111 held with each requester dropping after its ack, re-raised next IDLE -> grant order 0, 1, 2, 0; with PRIORITY_MODE = 1 the order is 0, 0, 0.
REQ-035 Flush: i_Flush pulsed during EXEC -> no o_Valid, no o_Ack, IDLE the next cycle, and the next grant goes to the RR successor.
REQ-036 Async reset: i_Reset asserted between edges during RESP -> all outputs go to their reset values before the next edge, with no o_Valid afterwards.
REQ-037 Operand change: i_Op1 changed from 0x8000 to 0x0000 in EXEC with i_Dec = 1 -> o_Result = 0x7FFF.
